// File: rtl/ffmul_sched.sv
// ffmul_sched: rotating-priority scheduler in front of one shared bit-serial
// GF(2^64) multiplier engine. One operation is in flight at a time. A request
// is granted in IDLE, launched with a single mul_start pulse, and then waited
// on until the engine reports idle. A watchdog aborts a stuck engine with a
// zero result and a sticky error flag.
module ffmul_sched #(
   parameter int N_REQ    = 3,
   parameter int WD_LIMIT = 80
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [64*N_REQ-1:0]  req_x,
   input  logic [64*N_REQ-1:0]  req_y,
   input  logic [64*N_REQ-1:0]  req_pol,
   output logic [N_REQ-1:0]     req_ready,
   output logic [N_REQ-1:0]     rsp_valid,
   output logic [63:0]          rsp_data,
   output logic                 mul_start,
   output logic [63:0]          mul_x,
   output logic [63:0]          mul_y,
   output logic [63:0]          mul_pol,
   input  logic [63:0]          mul_result,
   input  logic                 mul_ready,
   output logic                 err_timeout
);

   localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CW = $clog2(WD_LIMIT + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT,
      S_RESP
   } state_t;

   state_t            state, state_nxt;
   logic [GW-1:0]     ptr;
   logic [GW-1:0]     g;
   logic [GW-1:0]     gnt_idx;
   logic              gnt_any;
   logic [N_REQ-1:0]  gnt_oh;
   logic [N_REQ-1:0]  g_oh;
   logic [CW-1:0]     wd_cnt;
   logic              wd_hit;
   logic [63:0]       x_q, y_q, pol_q;
   logic [GW+5:0]     sel_base;

   // The watchdog fires on the last permitted WAIT cycle, so a stuck engine
   // costs exactly WD_LIMIT WAIT cycles before the abort response.
   assign wd_hit   = (wd_cnt == CW'(WD_LIMIT - 1));
   assign gnt_oh   = N_REQ'(1) << gnt_idx;
   assign g_oh     = N_REQ'(1) << g;
   assign sel_base = {gnt_idx, 6'b0};

   assign mul_x    = x_q;
   assign mul_y    = y_q;
   assign mul_pol  = pol_q;

   // Rotating priority search: first valid requester at or above ptr, wrapping.
   always_comb begin
      int idx;
      idx     = 0;
      gnt_any = 1'b0;
      gnt_idx = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!gnt_any && req_valid[idx]) begin
            gnt_any = 1'b1;
            gnt_idx = GW'(idx);
         end
      end
   end

   // Accept strobe is combinational and only ever offered from IDLE outside reset.
   always_comb begin
      req_ready = '0;
      if (state == S_IDLE && !rst && gnt_any) req_ready = gnt_oh;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode and engine load strobe. mul_ready is only looked at in WAIT;
   // by the first WAIT cycle the engine has already absorbed the LAUNCH pulse.
   always_comb begin
      state_nxt = state;
      mul_start = 1'b0;
      case (state)
         S_IDLE:   if (gnt_any) state_nxt = S_LAUNCH;
         S_LAUNCH: begin
            mul_start = 1'b1;
            state_nxt = S_WAIT;
         end
         S_WAIT:   if (mul_ready || wd_hit) state_nxt = S_RESP;
         S_RESP:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Operand capture, watchdog count, result capture and pointer rotation.
   always_ff @(posedge clk) begin
      if (rst) begin
         x_q         <= '0;
         y_q         <= '0;
         pol_q       <= '0;
         g           <= '0;
         ptr         <= '0;
         wd_cnt      <= '0;
         rsp_data    <= '0;
         rsp_valid   <= '0;
         err_timeout <= 1'b0;
      end else begin
         rsp_valid <= '0;
         case (state)
            S_IDLE: begin
               if (gnt_any) begin
                  x_q   <= req_x[sel_base +: 64];
                  y_q   <= req_y[sel_base +: 64];
                  pol_q <= req_pol[sel_base +: 64];
                  g     <= gnt_idx;
               end
            end
            S_LAUNCH: wd_cnt <= '0;
            S_WAIT: begin
               if (mul_ready) begin
                  rsp_data  <= mul_result;
                  rsp_valid <= g_oh;
               end else if (wd_hit) begin
                  rsp_data    <= '0;
                  rsp_valid   <= g_oh;
                  err_timeout <= 1'b1;
               end else begin
                  wd_cnt <= CW'(wd_cnt + 1'b1);
               end
            end
            S_RESP: begin
               if (int'(g) == N_REQ - 1) ptr <= '0;
               else                      ptr <= GW'(g + 1'b1);
            end
            default: ;
         endcase
      end
   end

endmodule
